// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous single-bit input into a clean registered level.
// Ports: clk, rst (sync, active-high), A (raw in), Out (level), rise/fall (pulses), busy.
module input_debouncer #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic A,
  output logic Out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  generate
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535) begin : g_bad_cfg
      $error("input_debouncer: STABLE_CYCLES out of range 2..65535");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s2_q;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  // A candidate level must be seen on s2 for STABLE_CYCLES
  // consecutive edges; one opposite sample restarts from scratch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (s2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2_q) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LOW: begin
        if (s2_q) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
    out_d  = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_q    <= A;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign Out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer (STABLE_CYCLES=4, 10 ns clock).
// Run-length reference model predicts {Out,rise,fall,busy} every edge.
module tb_input_debouncer;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  logic A;
  logic Out, rise, fall, busy;

  input_debouncer #(.STABLE_CYCLES(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .Out  (Out),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [3:0] sb[$];
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_out = 1'b0;
  int   m_run = 0;
  int   e = 0;
  int   up_edge = -1, dn_edge = -1;
  int   rise_n = 0, fall_n = 0;
  logic prev_out = 1'b0;

  task automatic model(input logic a, input logic r);
    logic mr, mf;
    mr = 1'b0;
    mf = 1'b0;
    if (r) begin
      m_s1 = 1'b0; m_s2 = 1'b0;
      m_out = 1'b0; m_run = 0;
    end else begin
      if (m_s2 != m_out) m_run++;
      else m_run = 0;
      if (m_run == N) begin
        m_out = ~m_out;
        mr = m_out;
        mf = ~m_out;
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = a;
    end
    sb.push_back({m_out, mr, mf, (m_run != 0)});
  endtask

  task automatic step(input logic a, input logic r);
    logic [3:0] exp;
    A = a;
    rst = r;
    @(posedge clk);
    e++;
    model(a, r);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      exp = sb.pop_front();
      chk($sformatf("edge%0d", e), {Out, rise, fall, busy}, exp);
    end
    if (rise && fall) chk("rise_fall_both", 1, 0);
    if (Out && !prev_out) up_edge = e;
    if (!Out && prev_out) dn_edge = e;
    if (rise) rise_n++;
    if (fall) fall_n++;
    prev_out = Out;
  endtask

  int k;
  int r0, f0;
  logic o0;

  initial begin
    A = 1'b0;
    rst = 1'b1;
    #2;
    // 1: reset, then quiet
    repeat (3) step(1'b0, 1'b1);
    chk("rst_out", Out, 0);
    chk("rst_busy", busy, 0);
    repeat (20) step(1'b0, 1'b0);
    chk("quiet_rise", rise_n, 0);
    chk("quiet_fall", fall_n, 0);

    // 2: rising edge, standard latency
    step(1'b1, 1'b0);
    k = e;
    repeat (9) step(1'b1, 1'b0);
    chk("rise_latency", up_edge - k, N + 1);
    chk("rise_count", rise_n, 1);
    chk("rise_nofall", fall_n, 0);

    // 3: falling edge
    step(1'b0, 1'b0);
    k = e;
    repeat (9) step(1'b0, 1'b0);
    chk("fall_latency", dn_edge - k, N + 1);
    chk("fall_count", fall_n, 1);
    chk("fall_norise", rise_n, 1);

    // 4: 3-cycle glitch rejected
    r0 = rise_n;
    repeat (3) step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    chk("glitch_out", Out, 0);
    chk("glitch_rise", rise_n - r0, 0);
    chk("glitch_busy", busy, 0);

    // 5: toggling every cycle
    o0 = Out; r0 = rise_n; f0 = fall_n;
    for (int i = 0; i < 50; i++) step(i[0] ? 1'b0 : 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    chk("tog_out", Out, o0);
    chk("tog_rise", rise_n - r0, 0);
    chk("tog_fall", fall_n - f0, 0);

    // 6: reset in WAIT_HIGH (cnt=2), A held high
    step(1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    chk("w6_busy", busy, 1);
    chk("w6_cnt", dut.cnt_q, 2);
    step(1'b1, 1'b1);
    chk("w6_rst_all", {Out, rise, fall, busy}, 0);
    chk("w6_state", dut.state_q, 0);
    r0 = rise_n;
    up_edge = -1;
    step(1'b1, 1'b0);
    k = e;
    repeat (9) step(1'b1, 1'b0);
    chk("w6_latency", up_edge - k, N + 1);
    chk("w6_rise", rise_n - r0, 1);

    // random tail, model-checked every edge
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Conditions a raw, asynchronous, bouncy single-bit input (push-button or switch) into a clean, clock-synchronous level before it drives the basic gate designs (not_gate1 and siblings).
- Sits directly upstream of the gate. Its Out level feeds the gate's A input.
- Also produces one-cycle rise and fall pulses for downstream counters and state machines.

Parameters:
- STABLE_CYCLES, default 4: consecutive identical synchronized samples required to accept a new level. Legal range 2..65535. Values below 2 are a configuration error.
- CNT_W, derived localparam, not overridable: $clog2(STABLE_CYCLES)+1, the width of the stability counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- A  input  1  raw asynchronous input. May glitch at any time.
- Out  output  1  debounced, registered level.
- rise  output  1  one-cycle pulse on the same edge Out goes 0->1.
- fall  output  1  one-cycle pulse on the same edge Out goes 1->0.
- busy  output  1  high while a candidate level change is being qualified.

Behaviour:
- Reset (rst=1 at an edge):
  - Sync flops s1 and s2 go to 0, cnt to 0, state to IDLE_LOW.
  - Out, rise, fall and busy all go to 0.
  - Reset overrides every other event on that edge.
- Synchronizer: two flops, s1<=A and s2<=s1. The FSM uses only s2.
- States: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
- Encoding: busy=1 exactly in the WAIT_* states. Out=1 in IDLE_HIGH and WAIT_LOW.
- IDLE_LOW:
  - s2=1: go to WAIT_HIGH, cnt<=1.
  - Otherwise stay, cnt<=0.
- WAIT_HIGH:
  - s2=0: return to IDLE_LOW, cnt<=0. The glitch is rejected, with no pulse.
  - s2=1 and cnt==STABLE_CYCLES-1: go to IDLE_HIGH, Out<=1, rise<=1.
  - Otherwise cnt<=cnt+1.
- IDLE_HIGH and WAIT_LOW mirror the two states above with the polarity inverted. The WAIT_LOW completion sets Out<=0 and fall<=1.
- rise and fall:
  - Registered, asserted for exactly one cycle, never both high at once.
  - Default to 0 on every edge they are not set.
- Latency: let k be the first edge at which s1 samples a new stable A. Out changes at edge k+STABLE_CYCLES+1, so s2 has held the new value for STABLE_CYCLES consecutive edges.
- Bounce inside the window: any opposite sample in a WAIT state aborts back to the originating IDLE state. The next qualifying sample restarts the count from 1, with no partial credit.
- cnt never exceeds STABLE_CYCLES-1 and never wraps.
- After reset, if A is held at 1, the block qualifies it normally. A rise pulse follows at the standard latency, and there is no suppression.
- X on A: the bench drives only 0 or 1. Behaviour under X is not specified.

Test Plan (STABLE_CYCLES=4, 10 ns clock):
1. Hold rst=1 for 3 edges with A=0, then release. Required: Out, rise, fall and busy are all 0 and stay 0 for 20 cycles.
2. A goes 0->1 sampled at edge k and is held. Required: busy=1 on edges k+2..k+4, Out=1 from edge k+5, rise=1 only in the cycle after edge k+5, fall stays 0.
3. From Out=1, A goes 1->0 and is held. Required: Out=0 at the 5th edge after sampling, fall is a single-cycle pulse, rise stays 0.
4. From Out=0, a 3-cycle high glitch on A. Required: Out stays 0, no rise, and busy returns to 0 one edge after s2 drops.
5. A toggles every cycle for 50 cycles. Required: Out never changes, rise and fall are never asserted.
6. Assert rst for one edge while in WAIT_HIGH (cnt=2), with A held at 1. Required: on the next edge everything reads 0 and the state is IDLE_LOW. Qualification then restarts and Out=1 follows at the standard latency.
